dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/cgra_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/dmem_rr_pick.sv | 50 +++++
 rtl/dmem_arbiter.sv | 82 ++++++++
 4 files changed

// File: rtl/cgra_pkg.sv
// cgra_pkg: shared CGRA sizes, dmem arbiter state encoding, opcodes.
// Build option DMEM_ARB_FIXED_PRIO_EN is read in dmem_rr_pick.sv.
package cgra_pkg;

    localparam int NUM_TILES   = 4;
    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 48;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic [2:0] {
        OP_MEM_SEND = 3'b001,
        OP_MEM_RECV = 3'b010
    } mem_op_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: tile request side and memory side of the arbiter.
// slave = arbiter view, master = tiles plus memory view.
interface dmem_arbiter_if
    import cgra_pkg::*;
#(
    parameter int NUM_REQ = NUM_TILES,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: winner selection among pending tile requests.
// DMEM_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module dmem_rr_pick
    import cgra_pkg::*;
#(
    parameter int NUM_REQ = NUM_TILES,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    assign any_req = |req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_winner;

    // lowest-index requester wins, history ignored
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) winner = IDX_W'(i);
        end
    end
`else
    // first requester above last_winner, wrapping
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] sel;
        logic             found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_winner) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = IDX_W'(idx);
            if (!found && req[sel]) begin
                winner = sel;
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port among tile requesters.
// Build option DMEM_ARB_FIXED_PRIO_EN: fixed priority instead of round-robin.
module dmem_arbiter
    import cgra_pkg::*;
#(
    parameter int NUM_REQ = NUM_TILES,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t       state;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] last_winner;
    logic [IDX_W-1:0] pick;
    logic             any_req;

    dmem_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req         (bus.req),
        .last_winner (last_winner),
        .winner      (pick),
        .any_req     (any_req)
    );

    // arbitration FSM; all strobes are registered one-cycle pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            winner        <= '0;
            last_winner   <= IDX_W'(NUM_REQ - 1);
            bus.gnt       <= '0;
            bus.rvalid    <= '0;
            bus.rdata     <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.gnt    <= '0;
            bus.rvalid <= '0;
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        winner        <= pick;
                        bus.gnt       <= NUM_REQ'(1) << pick;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= bus.we[pick];
                        bus.mem_addr  <= bus.addr[pick*ADDR_W +: ADDR_W];
                        bus.mem_wdata <= bus.wdata[pick*DATA_W +: DATA_W];
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    last_winner <= winner;
                    state       <= bus.mem_we ? IDLE : RDWAIT;
                end
                RDWAIT: begin
                    bus.rdata  <= bus.mem_rdata;
                    bus.rvalid <= NUM_REQ'(1) << winner;
                    state      <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
